div_window_counter: RTL and testbench

- divclk-domain front-end of the AFC frequency-compare path.
- Counts divclk cycles during a measurement window that is generated in the refclk domain.
- Returns the count to the refclk domain through a toggle handshake, where it feeds the count comparator.
- Replaces free-running divclk counting with a CDC-safe, captured, stable result.

---
 rtl/div_window_counter_if.sv | 22 ++
 rtl/div_window_counter.sv | 117 +++++++++++
 tb/tb_div_window_counter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_window_counter_if.sv
// Window-gate / abort request and captured-count result bundle between the refclk-side controller and the divclk counter.
interface div_window_counter_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   gate_async;
    logic                   abort_async;
    logic [COUNT_WIDTH-1:0] count_out;
    logic                   result_tgl;
    logic                   busy;
    logic                   overflow;
    logic                   timeout;

    modport master (
        output gate_async, abort_async,
        input  count_out, result_tgl, busy, overflow, timeout
    );

    modport slave (
        input  gate_async, abort_async,
        output count_out, result_tgl, busy, overflow, timeout
    );
endinterface

// File: rtl/div_window_counter.sv
// Counts divclk cycles while the synchronised refclk gate is high and publishes the count with a toggle handshake.
// Result lands 1 divclk after gate_s falls; no backpressure, consumer samples count_out after the toggle edge.
module div_window_counter #(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_WINDOW  = 0
) (
    input  logic                 divclk,
    input  logic                 rst_n,
    div_window_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] WIN_LIMIT  = COUNT_WIDTH'(MAX_WINDOW);
    localparam bit                     TIMEOUT_EN = (MAX_WINDOW != 0);

    logic [SYNC_STAGES-1:0] r_gate_sync;
    logic [SYNC_STAGES-1:0] r_abort_sync;
    logic                   r_gate_d;
    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_sat;
    logic [COUNT_WIDTH-1:0] r_count_out;
    logic                   r_result_tgl;
    logic                   r_busy;
    logic                   r_overflow;
    logic                   r_timeout;

    logic w_gate_s;
    logic w_abort_s;
    logic w_rise;

    assign w_gate_s  = r_gate_sync[SYNC_STAGES-1];
    assign w_abort_s = r_abort_sync[SYNC_STAGES-1];
    assign w_rise    = w_gate_s & ~r_gate_d;

    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_sync  <= '0;
            r_abort_sync <= '0;
            r_gate_d     <= 1'b0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_count_out  <= '0;
            r_result_tgl <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_gate_sync  <= {r_gate_sync[SYNC_STAGES-2:0], bus.gate_async};
            r_abort_sync <= {r_abort_sync[SYNC_STAGES-2:0], bus.abort_async};
            r_gate_d     <= w_gate_s;

            // Abort discards the measurement without publishing anything.
            if (w_abort_s) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= COUNT;
                            r_cnt   <= CNT_ONE;
                            r_sat   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    COUNT: begin
                        if (!w_gate_s) begin
                            r_count_out  <= r_cnt;
                            r_result_tgl <= ~r_result_tgl;
                            r_overflow   <= r_sat;
                            r_timeout    <= 1'b0;
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                        end else if (TIMEOUT_EN && (r_cnt == WIN_LIMIT)) begin
                            r_count_out  <= WIN_LIMIT;
                            r_result_tgl <= ~r_result_tgl;
                            r_overflow   <= r_sat;
                            r_timeout    <= 1'b1;
                            r_state      <= WAIT_LOW;
                        end else if (r_cnt == CNT_MAX) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    WAIT_LOW: begin
                        if (!w_gate_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count_out  = r_count_out;
    assign bus.result_tgl = r_result_tgl;
    assign bus.busy       = r_busy;
    assign bus.overflow   = r_overflow;
    assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_div_window_counter.sv
// Directed bench: three instances (plain, MAX_WINDOW=20, COUNT_WIDTH=4) share one gate/abort stimulus.
module tb_div_window_counter;
    logic divclk = 1'b0;
    logic rst_n  = 1'b0;
    logic gate   = 1'b1;
    logic abort  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 divclk = ~divclk;

    div_window_counter_if #(.COUNT_WIDTH(16)) if_a ();
    div_window_counter_if #(.COUNT_WIDTH(16)) if_b ();
    div_window_counter_if #(.COUNT_WIDTH(4))  if_c ();

    assign if_a.gate_async  = gate;
    assign if_a.abort_async = abort;
    assign if_b.gate_async  = gate;
    assign if_b.abort_async = abort;
    assign if_c.gate_async  = gate;
    assign if_c.abort_async = abort;

    div_window_counter #(.COUNT_WIDTH(16), .SYNC_STAGES(2), .MAX_WINDOW(0))
        dut_a (.divclk(divclk), .rst_n(rst_n), .bus(if_a));
    div_window_counter #(.COUNT_WIDTH(16), .SYNC_STAGES(2), .MAX_WINDOW(20))
        dut_b (.divclk(divclk), .rst_n(rst_n), .bus(if_b));
    div_window_counter #(.COUNT_WIDTH(4), .SYNC_STAGES(2), .MAX_WINDOW(0))
        dut_c (.divclk(divclk), .rst_n(rst_n), .bus(if_c));

    task automatic step();
        @(posedge divclk);
        #1;
    endtask

    // Gate high for exactly n edges, then enough low cycles for every instance to settle in IDLE.
    task automatic run_window(input int n);
        gate = 1'b1;
        repeat (n) step();
        gate = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (if_a.count_out !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", if_a.count_out); end
        checks++; if (if_a.result_tgl !== 1'b0) begin errors++; $display("FAIL rst_tgl: got %b want 0", if_a.result_tgl); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", if_a.busy); end
        checks++; if (if_a.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", if_a.overflow); end
        checks++; if (if_a.timeout !== 1'b0) begin errors++; $display("FAIL rst_to: got %b want 0", if_a.timeout); end
        repeat (3) step();
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b want 0", if_a.busy); end
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL rel_busy_early: got %b want 0", if_a.busy); end
        step();
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL rel_busy_rise: got %b want 1", if_a.busy); end
        repeat (97) step();
        gate = 1'b0;
        repeat (6) step();
        checks++; if (if_a.count_out !== 16'd100) begin errors++; $display("FAIL rel_count: got %0d want 100", if_a.count_out); end
        checks++; if (if_a.result_tgl !== 1'b1) begin errors++; $display("FAIL rel_tgl: got %b want 1", if_a.result_tgl); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL rel_busy_end: got %b want 0", if_a.busy); end
    endtask

    task automatic test_basic();
        run_window(50);
        checks++; if (if_a.count_out !== 16'd50) begin errors++; $display("FAIL w50_count: got %0d want 50", if_a.count_out); end
        checks++; if (if_a.result_tgl !== 1'b0) begin errors++; $display("FAIL w50_tgl: got %b want 0", if_a.result_tgl); end
        checks++; if (if_a.overflow !== 1'b0) begin errors++; $display("FAIL w50_ovf: got %b want 0", if_a.overflow); end
        checks++; if (if_a.timeout !== 1'b0) begin errors++; $display("FAIL w50_to: got %b want 0", if_a.timeout); end
        run_window(73);
        checks++; if (if_a.count_out !== 16'd73) begin errors++; $display("FAIL w73_count: got %0d want 73", if_a.count_out); end
        checks++; if (if_a.result_tgl !== 1'b1) begin errors++; $display("FAIL w73_tgl: got %b want 1", if_a.result_tgl); end
    endtask

    task automatic test_timeout();
        int first_tgl = -1;
        int n_tgl     = 0;
        logic last    = 1'b1;
        gate = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (if_b.result_tgl !== last) begin
                n_tgl++;
                last = if_b.result_tgl;
                if (first_tgl < 0) first_tgl = i;
            end
        end
        checks++; if (if_b.busy !== 1'b1) begin errors++; $display("FAIL to_busy_high: got %b want 1", if_b.busy); end
        gate = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (if_b.result_tgl !== last) begin
                n_tgl++;
                last = if_b.result_tgl;
            end
            if (i == 2) begin
                checks++; if (if_b.busy !== 1'b1) begin errors++; $display("FAIL to_busy_wait: got %b want 1", if_b.busy); end
            end
            if (i == 3) begin
                checks++; if (if_b.busy !== 1'b0) begin errors++; $display("FAIL to_busy_drop: got %b want 0", if_b.busy); end
            end
        end
        checks++; if (first_tgl !== 23) begin errors++; $display("FAIL to_tgl_cycle: got %0d want 23", first_tgl); end
        checks++; if (n_tgl !== 1) begin errors++; $display("FAIL to_tgl_count: got %0d want 1", n_tgl); end
        checks++; if (if_b.count_out !== 16'd20) begin errors++; $display("FAIL to_count: got %0d want 20", if_b.count_out); end
        checks++; if (if_b.timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", if_b.timeout); end
        checks++; if (if_b.overflow !== 1'b0) begin errors++; $display("FAIL to_ovf: got %b want 0", if_b.overflow); end
        run_window(10);
        checks++; if (if_b.count_out !== 16'd10) begin errors++; $display("FAIL to_next_count: got %0d want 10", if_b.count_out); end
        checks++; if (if_b.timeout !== 1'b0) begin errors++; $display("FAIL to_next_flag: got %b want 0", if_b.timeout); end
        checks++; if (if_b.result_tgl !== 1'b1) begin errors++; $display("FAIL to_next_tgl: got %b want 1", if_b.result_tgl); end
    endtask

    task automatic test_overflow();
        run_window(30);
        checks++; if (if_c.count_out !== 4'd15) begin errors++; $display("FAIL ovf_count: got %0d want 15", if_c.count_out); end
        checks++; if (if_c.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", if_c.overflow); end
        checks++; if (if_c.result_tgl !== 1'b0) begin errors++; $display("FAIL ovf_tgl: got %b want 0", if_c.result_tgl); end
        run_window(5);
        checks++; if (if_c.count_out !== 4'd5) begin errors++; $display("FAIL ovf_next_count: got %0d want 5", if_c.count_out); end
        checks++; if (if_c.overflow !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %b want 0", if_c.overflow); end
        checks++; if (if_a.count_out !== 16'd5) begin errors++; $display("FAIL ovf_a_count: got %0d want 5", if_a.count_out); end
    endtask

    task automatic test_abort();
        gate = 1'b1;
        repeat (25) step();
        abort = 1'b1;
        repeat (2) step();
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL ab_busy_pre: got %b want 1", if_a.busy); end
        step();
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL ab_busy_drop: got %b want 0", if_a.busy); end
        gate = 1'b0;
        repeat (6) step();
        checks++; if (if_a.result_tgl !== 1'b1) begin errors++; $display("FAIL ab_no_tgl: got %b want 1", if_a.result_tgl); end
        checks++; if (if_a.count_out !== 16'd5) begin errors++; $display("FAIL ab_count_kept: got %0d want 5", if_a.count_out); end
        checks++; if (if_c.result_tgl !== 1'b1) begin errors++; $display("FAIL ab_c_no_tgl: got %b want 1", if_c.result_tgl); end
        gate = 1'b1;
        repeat (8) step();
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL ab_rise_ignored: got %b want 0", if_a.busy); end
        gate = 1'b0;
        repeat (4) step();
        abort = 1'b0;
        repeat (4) step();
        checks++; if (if_a.result_tgl !== 1'b1) begin errors++; $display("FAIL ab_release_tgl: got %b want 1", if_a.result_tgl); end
        run_window(12);
        checks++; if (if_a.count_out !== 16'd12) begin errors++; $display("FAIL ab_next_count: got %0d want 12", if_a.count_out); end
        checks++; if (if_a.result_tgl !== 1'b0) begin errors++; $display("FAIL ab_next_tgl: got %b want 0", if_a.result_tgl); end
        checks++; if (if_c.count_out !== 4'd12) begin errors++; $display("FAIL ab_c_count: got %0d want 12", if_c.count_out); end
    endtask

    task automatic test_back_to_back();
        int   n_tgl = 0;
        logic last  = 1'b0;
        logic [15:0] seen [2];
        seen[0] = '0;
        seen[1] = '0;
        gate = 1'b1;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", if_a.busy); end
        checks++; if (if_a.count_out !== 16'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", if_a.count_out); end
        checks++; if (if_a.result_tgl !== 1'b0) begin errors++; $display("FAIL mid_rst_tgl: got %b want 0", if_a.result_tgl); end
        gate = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 40; i++) begin
            gate = (i < 8) || (i >= 10 && i < 19);
            step();
            if (if_a.result_tgl !== last) begin
                last = if_a.result_tgl;
                if (n_tgl < 2) seen[n_tgl] = if_a.count_out;
                n_tgl++;
            end
        end
        checks++; if (n_tgl !== 2) begin errors++; $display("FAIL b2b_tgl_count: got %0d want 2", n_tgl); end
        checks++; if (seen[0] !== 16'd8) begin errors++; $display("FAIL b2b_first: got %0d want 8", seen[0]); end
        checks++; if (seen[1] !== 16'd9) begin errors++; $display("FAIL b2b_second: got %0d want 9", seen[1]); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", if_a.busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
